// File: rtl/s_div_pkg.sv
// rtl/s_div_pkg.sv - shared types and constants for the restoring divider
package s_div_pkg;
   localparam int S_DIV_BIT = 8;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } s_div_state_e;

   // Wide enough for any practical 2*BIT; the top slices what it needs.
   localparam logic [63:0] S_DIV_ONES = '1;
endpackage

// File: rtl/s_div_step.sv
// rtl/s_div_step.sv - one combinational shift-subtract iteration of the divider
module s_div_step
   import s_div_pkg::*;
#(
   parameter int BIT = S_DIV_BIT
) (
   input  logic [BIT:0]     r_i,
   input  logic [2*BIT-1:0] q_i,
   input  logic [BIT-1:0]   d_i,
   output logic [BIT:0]     r_o,
   output logic [2*BIT-1:0] q_o
);
   logic [BIT:0]   rs;
   logic [BIT+1:0] t;
   logic           unused_r_msb;

   // The partial remainder's top bit is shifted out each iteration.
   assign rs           = {r_i[BIT-1:0], q_i[2*BIT-1]};
   assign t            = {1'b0, rs} - {2'b00, d_i};
   assign unused_r_msb = r_i[BIT];

   always_comb begin
      r_o = rs;
      q_o = {q_i[2*BIT-2:0], 1'b0};
      if (!t[BIT+1]) begin
         r_o    = t[BIT:0];
         q_o[0] = 1'b1;
      end
   end
endmodule

// File: rtl/s_divider.sv
// rtl/s_divider.sv - sequential restoring divider, one quotient bit per clock
// Optional S_DIV_DIV0_EN: zero divisor finishes immediately and raises div0.
module s_divider
   import s_div_pkg::*;
#(
   parameter int BIT   = S_DIV_BIT,
   parameter int CNT_W = $clog2(2*BIT+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2*BIT-1:0] dividend,
   input  logic [BIT-1:0]   divisor,
   output logic             busy,
   output logic             done,
   output logic [2*BIT-1:0] quotient,
`ifdef S_DIV_DIV0_EN
   output logic [BIT-1:0]   remainder,
   output logic             div0
`else
   output logic [BIT-1:0]   remainder
`endif
);
   localparam logic [2*BIT-1:0] Q_ONES   = S_DIV_ONES[2*BIT-1:0];
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(2*BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   s_div_state_e     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [BIT:0]     r_q, r_d;
   logic [2*BIT-1:0] q_q, q_d;
   logic [BIT-1:0]   d_q;
   logic             busy_q, done_q;
   logic [2*BIT-1:0] quot_q;
   logic [BIT-1:0]   rem_q;
   logic             div0_q;

   s_div_step #(.BIT(BIT)) u_step (
      .r_i (r_q),
      .q_i (q_q),
      .d_i (d_q),
      .r_o (r_d),
      .q_o (q_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         div0_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
`ifdef S_DIV_DIV0_EN
                  if (divisor == '0) begin
                     quot_q <= Q_ONES;
                     rem_q  <= dividend[BIT-1:0];
                     div0_q <= 1'b1;
                     done_q <= 1'b1;
                  end else begin
                     q_q     <= dividend;
                     r_q     <= '0;
                     d_q     <= divisor;
                     cnt_q   <= CNT_INIT;
                     busy_q  <= 1'b1;
                     div0_q  <= 1'b0;
                     state_q <= CALC;
                  end
`else
                  q_q     <= dividend;
                  r_q     <= '0;
                  d_q     <= divisor;
                  cnt_q   <= CNT_INIT;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
`endif
               end
            end
            CALC: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_LAST) begin
                  quot_q  <= q_d;
                  rem_q   <= r_d[BIT-1:0];
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;
`ifdef S_DIV_DIV0_EN
   assign div0      = div0_q;
`else
   logic unused_div0;
   assign unused_div0 = div0_q;
`endif
endmodule

// File: tb/tb_s_divider.sv
// tb/tb_s_divider.sv - directed self-checking bench for s_divider (BIT=8)
module tb_s_divider;
   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [7:0]  remainder;
`ifdef S_DIV_DIV0_EN
   logic        div0;
   localparam int DIV0_LAT = 0;
`else
   localparam int DIV0_LAT = 16;
`endif

   int n_pass  = 0;
   int n_total = 0;

   s_divider #(.BIT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
`ifdef S_DIV_DIV0_EN
      .remainder (remainder),
      .div0      (div0)
`else
      .remainder (remainder)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [15:0] n, input logic [7:0] d);
      dividend = n;
      divisor  = d;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   // Advances from the current cycle until done is seen or the budget runs out.
   task automatic wait_done(input int budget, output int cycles, output bit ok);
      cycles = 0;
      while (done !== 1'b1 && cycles < budget) begin
         step();
         cycles++;
      end
      ok = (done === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      step(); step();
      n_total++;
      if ({busy, done, quotient, remainder} !== 26'd0)
         $display("FAIL reset_state: busy=%b done=%b q=%h r=%h, need all 0", busy, done, quotient, remainder);
      else n_pass++;
`ifdef S_DIV_DIV0_EN
      n_total++;
      if (div0 !== 1'b0) $display("FAIL reset_div0: got %b need 0", div0);
      else n_pass++;
`endif
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int bad_busy = 0;
      go(16'd1000, 8'd7);
      for (int k = 1; k <= 16; k++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
         step();
      end
      n_total++;
      if (bad_busy != 0) $display("FAIL basic_busy_window: %0d bad cycles, need 0", bad_busy);
      else n_pass++;
      n_total++;
      if (done !== 1'b1 || busy !== 1'b0)
         $display("FAIL basic_done_lat16: done=%b busy=%b, need done=1 busy=0", done, busy);
      else n_pass++;
      n_total++;
      if (quotient !== 16'd142 || remainder !== 8'd6)
         $display("FAIL basic_result: q=%0d r=%0d, need q=142 r=6", quotient, remainder);
      else n_pass++;
      step();
      n_total++;
      if (done !== 1'b0) $display("FAIL basic_done_width: done=%b, need 0", done);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int cyc; bit ok;
      dividend = 16'hFFFF; divisor = 8'hFF; start = 1'b1;
      step();
      dividend = 16'hFFFF; divisor = 8'h01;
      wait_done(40, cyc, ok);
      n_total++;
      if (!ok || cyc != 16 || quotient !== 16'h0101 || remainder !== 8'h00)
         $display("FAIL b2b_op1: ok=%0d lat=%0d q=%h r=%h, need lat=16 q=0101 r=00", ok, cyc, quotient, remainder);
      else n_pass++;
      step();
      n_total++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL b2b_reaccept: busy=%b done=%b, need busy=1 done=0", busy, done);
      else n_pass++;
      dividend = 16'd5; divisor = 8'd9;
      wait_done(40, cyc, ok);
      n_total++;
      if (!ok || cyc != 16 || quotient !== 16'hFFFF || remainder !== 8'h00)
         $display("FAIL b2b_op2: ok=%0d lat=%0d q=%h r=%h, need lat=16 q=ffff r=00", ok, cyc, quotient, remainder);
      else n_pass++;
      step();
      start = 1'b0;
      wait_done(40, cyc, ok);
      n_total++;
      if (!ok || cyc != 16 || quotient !== 16'd0 || remainder !== 8'd5)
         $display("FAIL b2b_op3: ok=%0d lat=%0d q=%0d r=%0d, need lat=16 q=0 r=5", ok, cyc, quotient, remainder);
      else n_pass++;
      step();
   endtask

   task automatic test_div_zero();
      int cyc; bit ok;
      go(16'h1234, 8'd0);
`ifdef S_DIV_DIV0_EN
      n_total++;
      if (busy !== 1'b0) $display("FAIL div0_busy: busy=%b, need 0", busy);
      else n_pass++;
`endif
      wait_done(40, cyc, ok);
      n_total++;
      if (!ok || cyc != DIV0_LAT || quotient !== 16'hFFFF || remainder !== 8'h34)
         $display("FAIL div0_result: ok=%0d lat=%0d q=%h r=%h, need lat=%0d q=ffff r=34", ok, cyc, quotient, remainder, DIV0_LAT);
      else n_pass++;
`ifdef S_DIV_DIV0_EN
      n_total++;
      if (div0 !== 1'b1) $display("FAIL div0_flag_set: div0=%b, need 1", div0);
      else n_pass++;
`endif
      step();
      go(16'd10, 8'd3);
      wait_done(40, cyc, ok);
      n_total++;
      if (!ok || quotient !== 16'd3 || remainder !== 8'd1)
         $display("FAIL div0_followup: ok=%0d q=%0d r=%0d, need q=3 r=1", ok, quotient, remainder);
      else n_pass++;
`ifdef S_DIV_DIV0_EN
      n_total++;
      if (div0 !== 1'b0) $display("FAIL div0_flag_clear: div0=%b, need 0", div0);
      else n_pass++;
`endif
      step();
   endtask

   task automatic test_mid_reset();
      int cyc; int pulses = 0; bit ok;
      go(16'd1000, 8'd7);
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_total++;
      if ({busy, done, quotient, remainder} !== 26'd0)
         $display("FAIL midrst_state: busy=%b done=%b q=%h r=%h, need all 0", busy, done, quotient, remainder);
      else n_pass++;
      for (int k = 0; k < 30; k++) begin
         if (done === 1'b1) pulses++;
         step();
      end
      n_total++;
      if (pulses != 0) $display("FAIL midrst_no_done: %0d pulses, need 0", pulses);
      else n_pass++;
      go(16'd200, 8'd13);
      wait_done(40, cyc, ok);
      n_total++;
      if (!ok || cyc != 16 || quotient !== 16'd15 || remainder !== 8'd5)
         $display("FAIL midrst_next_op: ok=%0d lat=%0d q=%0d r=%0d, need lat=16 q=15 r=5", ok, cyc, quotient, remainder);
      else n_pass++;
      step();
   endtask

   task automatic test_start_while_busy();
      int cyc; int pulses = 0; bit ok;
      go(16'd1000, 8'd7);
      step(); step(); step();
      dividend = 16'd100; divisor = 8'd3; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(40, cyc, ok);
      n_total++;
      if (!ok || cyc != 12 || quotient !== 16'd142 || remainder !== 8'd6)
         $display("FAIL busy_start_ignored: ok=%0d lat=%0d q=%0d r=%0d, need lat=12 q=142 r=6", ok, cyc, quotient, remainder);
      else n_pass++;
      step();
      for (int k = 0; k < 24; k++) begin
         if (done === 1'b1) pulses++;
         step();
      end
      n_total++;
      if (pulses != 0) $display("FAIL busy_start_extra_done: %0d extra pulses, need 0", pulses);
      else n_pass++;
   endtask

   task automatic test_random();
      int cyc; int bad = 0; bit ok;
      logic [15:0] n; logic [7:0] d;
      int unsigned eq, er;
      for (int i = 0; i < 1000; i++) begin
         n = 16'($urandom);
         d = 8'($urandom_range(255, 1));
         eq = 32'(n) / 32'(d);
         er = 32'(n) % 32'(d);
         go(n, d);
         wait_done(40, cyc, ok);
         if (!ok || cyc != 16 || 32'(quotient) != eq || 32'(remainder) != er ||
             32'(quotient) * 32'(d) + 32'(remainder) != 32'(n) || remainder >= d) begin
            bad++;
            if (bad <= 5)
               $display("FAIL random_op: n=%0d d=%0d q=%0d r=%0d lat=%0d, need q=%0d r=%0d lat=16", n, d, quotient, remainder, cyc, eq, er);
         end
         step();
      end
      n_total++;
      if (bad != 0) $display("FAIL random_summary: %0d bad ops, need 0", bad);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      #1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_mid_reset();
      test_start_while_busy();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
